// File: rtl/rampgen_sweep_ctrl.sv
// rampgen_sweep_ctrl: steps a ramp generator through a table of {frequency, amplitude, beats} segments.
//   M_AXIS_ACLK / M_AXIS_ARESETN : clock, async active-low reset (also clears the table)
//   start / stop / loop_en       : sweep control; last_seg is the final table index
//   cfg_*                        : table write port, usable in any state
//   mon_tvalid / mon_tready      : monitored ramp-generator handshake, one beat per transfer
//   frequency / amplitude        : ramp generator settings, zero while idle
//   busy / seg_idx / seg_done / sweep_done : status
module rampgen_sweep_ctrl #(
   parameter  int NSEG   = 4,
   parameter  int BEAT_W = 16,
   localparam int AW     = $clog2(NSEG)
) (
   input  logic              M_AXIS_ACLK,
   input  logic              M_AXIS_ARESETN,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [AW-1:0]     last_seg,
   input  logic              cfg_we,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [31:0]       cfg_freq,
   input  logic [31:0]       cfg_amp,
   input  logic [BEAT_W-1:0] cfg_beats,
   input  logic              mon_tvalid,
   input  logic              mon_tready,
   output logic [31:0]       frequency,
   output logic [31:0]       amplitude,
   output logic              busy,
   output logic [AW-1:0]     seg_idx,
   output logic              seg_done,
   output logic              sweep_done
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t            state_q, state_d;
   logic [AW-1:0]     seg_q, seg_d, last_q, last_d;
   logic [BEAT_W-1:0] cnt_q, cnt_d;
   logic [31:0]       freq_q, freq_d, amp_q, amp_d;
   logic              seg_done_q, seg_done_d, sweep_done_q, sweep_done_d;
   logic [31:0]       freq_tab_q  [NSEG];
   logic [31:0]       amp_tab_q   [NSEG];
   logic [BEAT_W-1:0] beats_tab_q [NSEG];
   logic [BEAT_W-1:0] beats_eff;
   logic              beat, seg_end;
   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN)
      if (!M_AXIS_ARESETN)
         for (int i = 0; i < NSEG; i++) begin
            freq_tab_q[i]  <= '0;
            amp_tab_q[i]   <= '0;
            beats_tab_q[i] <= '0;
         end
      else if (cfg_we) begin
         freq_tab_q[cfg_addr]  <= cfg_freq;
         amp_tab_q[cfg_addr]   <= cfg_amp;
         beats_tab_q[cfg_addr] <= cfg_beats;
      end
   // beats is read live; >= guards against the table shrinking below the running count
   assign beats_eff = (beats_tab_q[seg_q] == '0) ? BEAT_W'(1) : beats_tab_q[seg_q];
   assign beat      = (state_q == RUN) && mon_tvalid && mon_tready;
   assign seg_end   = beat && (cnt_q >= beats_eff - BEAT_W'(1));
   always_comb begin
      state_d      = state_q;
      seg_d        = seg_q;
      last_d       = last_q;
      cnt_d        = cnt_q;
      freq_d       = freq_q;
      amp_d        = amp_q;
      seg_done_d   = 1'b0;
      sweep_done_d = 1'b0;
      if (state_q == IDLE) begin
         if (start && !stop) begin
            state_d = RUN;
            seg_d   = '0;
            last_d  = last_seg;
            cnt_d   = '0;
            freq_d  = freq_tab_q[0];
            amp_d   = amp_tab_q[0];
         end
      end else if (stop) begin
         state_d = IDLE;
         seg_d   = '0;
         cnt_d   = '0;
         freq_d  = '0;
         amp_d   = '0;
      end else if (seg_end) begin
         cnt_d      = '0;
         seg_done_d = 1'b1;
         if (seg_q < last_q || loop_en) begin
            seg_d  = (seg_q < last_q) ? seg_q + AW'(1) : '0;
            freq_d = freq_tab_q[seg_d];
            amp_d  = amp_tab_q[seg_d];
         end else begin
            state_d      = IDLE;
            seg_d        = '0;
            freq_d       = '0;
            amp_d        = '0;
            sweep_done_d = 1'b1;
         end
      end else if (beat)
         cnt_d = cnt_q + BEAT_W'(1);
   end
   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN)
      if (!M_AXIS_ARESETN) begin
         state_q      <= IDLE;
         seg_q        <= '0;
         last_q       <= '0;
         cnt_q        <= '0;
         freq_q       <= '0;
         amp_q        <= '0;
         seg_done_q   <= 1'b0;
         sweep_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         seg_q        <= seg_d;
         last_q       <= last_d;
         cnt_q        <= cnt_d;
         freq_q       <= freq_d;
         amp_q        <= amp_d;
         seg_done_q   <= seg_done_d;
         sweep_done_q <= sweep_done_d;
      end
   assign frequency  = freq_q;
   assign amplitude  = amp_q;
   assign busy       = (state_q == RUN);
   assign seg_idx    = seg_q;
   assign seg_done   = seg_done_q;
   assign sweep_done = sweep_done_q;
endmodule

// File: tb/tb_rampgen_sweep_ctrl.sv
// tb_rampgen_sweep_ctrl: directed self-checking bench for rampgen_sweep_ctrl.
module tb_rampgen_sweep_ctrl;
   localparam int AW = 2;
   logic          clk = 1'b0, rst_n = 1'b0;
   logic          start = 0, stop = 0, loop_en = 0, cfg_we = 0, tvalid = 0, tready = 0;
   logic [AW-1:0] last_seg = '0, cfg_addr = '0;
   logic [31:0]   cfg_freq = '0, cfg_amp = '0;
   logic [15:0]   cfg_beats = '0;
   logic [31:0]   frequency, amplitude;
   logic          busy, seg_done, sweep_done;
   logic [AW-1:0] seg_idx;
   int            checks = 0, failures = 0;
   rampgen_sweep_ctrl #(.NSEG(4), .BEAT_W(16)) dut (
      .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .start(start), .stop(stop),
      .loop_en(loop_en), .last_seg(last_seg), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_freq(cfg_freq), .cfg_amp(cfg_amp), .cfg_beats(cfg_beats),
      .mon_tvalid(tvalid), .mon_tready(tready), .frequency(frequency),
      .amplitude(amplitude), .busy(busy), .seg_idx(seg_idx), .seg_done(seg_done),
      .sweep_done(sweep_done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // advance one clock, then check the full status picture
   task automatic cyc(input string tag, input logic [31:0] f, input logic [AW-1:0] s,
                      input logic sd, input logic sw, input logic b);
      @(posedge clk);
      #1;
      chk({tag, ".freq"}, frequency, f);
      chk({tag, ".seg"}, 32'(seg_idx), 32'(s));
      chk({tag, ".seg_done"}, 32'(seg_done), 32'(sd));
      chk({tag, ".sweep_done"}, 32'(sweep_done), 32'(sw));
      chk({tag, ".busy"}, 32'(busy), 32'(b));
   endtask
   task automatic wr(input logic [AW-1:0] a, input logic [31:0] f, input logic [31:0] m,
                     input logic [15:0] n);
      cfg_we = 1; cfg_addr = a; cfg_freq = f; cfg_amp = m; cfg_beats = n;
      @(posedge clk);
      #1;
      cfg_we = 0;
   endtask
   initial begin
      #2;
      chk("rst.freq", frequency, 0);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.sd", 32'(seg_done), 0);
      #10 rst_n = 1;
      @(posedge clk);
      #1;
      wr(0, 32'd40000, 32'hFFFFFFFF, 16'd3);
      wr(1, 32'd80000, 32'h7FFFFFFF, 16'd2);
      // single sweep, loop disabled
      tvalid = 1; tready = 1; last_seg = 1; loop_en = 0; start = 1;
      cyc("s0", 40000, 0, 0, 0, 1);
      start = 0;
      chk("s0.amp", amplitude, 32'hFFFFFFFF);
      cyc("s1", 40000, 0, 0, 0, 1);
      cyc("s2", 40000, 0, 0, 0, 1);
      cyc("s3", 80000, 1, 1, 0, 1);
      chk("s3.amp", amplitude, 32'h7FFFFFFF);
      cyc("s4", 80000, 1, 0, 0, 1);
      cyc("s5", 0, 0, 1, 1, 0);
      chk("s5.amp", amplitude, 0);
      cyc("s6", 0, 0, 0, 0, 0);
      // looping sweep with a mid-segment rewrite of entry 0, then stop on the final beat
      loop_en = 1; start = 1;
      cyc("l0", 40000, 0, 0, 0, 1);
      start = 0; cfg_we = 1; cfg_addr = 0; cfg_freq = 12345; cfg_amp = 32'hFFFFFFFF; cfg_beats = 3;
      cyc("l1", 40000, 0, 0, 0, 1);
      cfg_we = 0;
      cyc("l2", 40000, 0, 0, 0, 1);
      cyc("l3", 80000, 1, 1, 0, 1);
      cyc("l4", 80000, 1, 0, 0, 1);
      cyc("l5", 12345, 0, 1, 0, 1);
      cyc("l6", 12345, 0, 0, 0, 1);
      cyc("l7", 12345, 0, 0, 0, 1);
      cyc("l8", 80000, 1, 1, 0, 1);
      cyc("l9", 80000, 1, 0, 0, 1);
      stop = 1;
      cyc("stop", 0, 0, 0, 0, 0);
      stop = 0;
      // handshake-gated counting, start ignored while running
      wr(0, 32'd40000, 32'hFFFFFFFF, 16'd2);
      last_seg = 0; loop_en = 0; start = 1;
      cyc("h0", 40000, 0, 0, 0, 1);
      tready = 1;
      cyc("h1", 40000, 0, 0, 0, 1);
      start = 0; tready = 0;
      cyc("h2", 40000, 0, 0, 0, 1);
      tready = 1;
      cyc("h3", 0, 0, 1, 1, 0);
      // start together with stop in idle does nothing
      start = 1; stop = 1;
      cyc("ss", 0, 0, 0, 0, 0);
      start = 0; stop = 0;
      // async reset mid-segment clears outputs and the table
      last_seg = 1; start = 1;
      cyc("r0", 40000, 0, 0, 0, 1);
      start = 0;
      #3 rst_n = 0;
      #1;
      chk("rst_async.freq", frequency, 0);
      chk("rst_async.busy", 32'(busy), 0);
      @(posedge clk);
      #3 rst_n = 1;
      cyc("r1", 0, 0, 0, 0, 0);
      start = 1;
      cyc("z0", 0, 0, 0, 0, 1);
      start = 0;
      cyc("z1", 0, 1, 1, 0, 1);
      cyc("z2", 0, 0, 1, 1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
